// File: rtl/tank_level_ctrl.sv
// Water-tank level controller: sample debounce, pump hysteresis,
// dry-run fault detection and pulsed buzzer alarm.
module tank_level_ctrl #(
  parameter int LVL_W       = 8,
  parameter int LOW_TH      = 64,
  parameter int HIGH_TH     = 192,
  parameter int ALARM_TH    = 240,
  parameter int STABLE_N    = 4,
  parameter int BUZZ_HALF   = 8,
  parameter int DRY_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_valid,
  input  logic [LVL_W-1:0] level_in,
  output logic [LVL_W-1:0] level,
  output logic             motor,
  output logic             led,
  output logic             buzzer,
  output logic             fault
);

  localparam int CW = $clog2(STABLE_N + 1);
  localparam int DW = $clog2(DRY_TIMEOUT);
  localparam int PW = $clog2(2 * BUZZ_HALF);

  localparam logic [LVL_W-1:0] L_LOW   = LVL_W'(LOW_TH);
  localparam logic [LVL_W-1:0] L_HIGH  = LVL_W'(HIGH_TH);
  localparam logic [LVL_W-1:0] L_ALARM = LVL_W'(ALARM_TH);
  localparam logic [CW-1:0]    C_N     = CW'(STABLE_N);
  localparam logic [CW-1:0]    C_ONE   = CW'(1);
  localparam logic [DW-1:0]    D_END   = DW'(DRY_TIMEOUT - 1);
  localparam logic [PW-1:0]    P_HALF  = PW'(BUZZ_HALF);
  localparam logic [PW-1:0]    P_END   = PW'(2 * BUZZ_HALF - 1);

  typedef enum logic [1:0] {
    S_OFF,
    S_IDLE,
    S_FILL,
    S_FAULT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LVL_W-1:0] r_cand;
  logic [LVL_W-1:0] r_level;
  logic [CW-1:0]    r_cnt;
  logic             r_lvl_ok;
  logic [DW-1:0]    r_dry;
  logic [PW-1:0]    r_phase;
  logic             r_buzz;

  logic w_upd;
  logic w_rise;
  logic w_ovf;
  logic w_alarm;

  assign w_upd   = (r_cnt == C_N) && (r_cand != r_level);
  assign w_rise  = w_upd && (r_cand > r_level);
  assign w_ovf   = r_level >= L_ALARM;
  assign w_alarm = w_ovf || (r_state == S_FAULT);

  // Filter runs regardless of controller state or enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand   <= '0;
      r_cnt    <= '0;
      r_level  <= '0;
      r_lvl_ok <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (level_in == r_cand) begin
          if (r_cnt != C_N) r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cand <= level_in;
          r_cnt  <= C_ONE;
        end
      end
      if (w_upd) begin
        r_level  <= r_cand;
        r_lvl_ok <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_OFF:   w_next = S_IDLE;
      S_IDLE: begin
        if (r_lvl_ok && (r_level <= L_LOW)) w_next = S_FILL;
      end
      S_FILL: begin
        if ((r_level >= L_HIGH) || w_ovf) w_next = S_IDLE;
        else if (r_dry == D_END)          w_next = S_FAULT;
      end
      S_FAULT: w_next = S_FAULT;
    endcase
    if (!enable) w_next = S_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_dry   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FILL) && (w_next == S_FILL))
        r_dry <= w_rise ? '0 : r_dry + 1'b1;
      else
        r_dry <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_buzz  <= 1'b0;
    end else if (!w_alarm) begin
      r_phase <= '0;
      r_buzz  <= 1'b0;
    end else begin
      r_buzz  <= r_phase < P_HALF;
      r_phase <= (r_phase == P_END) ? '0 : r_phase + 1'b1;
    end
  end

  assign level  = r_level;
  assign motor  = (r_state == S_FILL) && !w_ovf;
  assign led    = r_lvl_ok && (r_level >= L_HIGH);
  assign buzzer = r_buzz;
  assign fault  = r_state == S_FAULT;

endmodule

// File: tb/tb_tank_level_ctrl.sv
// Scoreboard bench for tank_level_ctrl: reference model pushes
// expected outputs per cycle, monitor pops and compares.
module tb_tank_level_ctrl;

  localparam int LVL_W       = 8;
  localparam int LOW_TH      = 64;
  localparam int HIGH_TH     = 192;
  localparam int ALARM_TH    = 240;
  localparam int STABLE_N    = 4;
  localparam int BUZZ_HALF   = 8;
  localparam int DRY_TIMEOUT = 1000;

  localparam int M_OFF   = 0;
  localparam int M_IDLE  = 1;
  localparam int M_FILL  = 2;
  localparam int M_FAULT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             sample_valid = 1'b0;
  logic [LVL_W-1:0] level_in = '0;
  logic [LVL_W-1:0] level;
  logic             motor;
  logic             led;
  logic             buzzer;
  logic             fault;

  always #5 clk = ~clk;

  tank_level_ctrl #(
    .LVL_W(LVL_W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH),
    .ALARM_TH(ALARM_TH), .STABLE_N(STABLE_N),
    .BUZZ_HALF(BUZZ_HALF), .DRY_TIMEOUT(DRY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sample_valid(sample_valid), .level_in(level_in),
    .level(level), .motor(motor), .led(led),
    .buzzer(buzzer), .fault(fault)
  );

  typedef struct packed {
    logic [LVL_W-1:0] lvl;
    logic mot;
    logic led;
    logic buz;
    logic flt;
  } obs_t;

  obs_t q[$];
  obs_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int m_last  = 0;
  int m_run   = 0;
  int m_level = 0;
  bit m_ok    = 0;
  int m_st    = M_OFF;
  int m_since = 0;
  int m_age   = 0;
  bit m_buzz  = 0;

  function automatic obs_t outs();
    obs_t o;
    o.lvl = LVL_W'(level);
    o.mot = motor;
    o.led = led;
    o.buz = buzzer;
    o.flt = fault;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t got lvl=%0d mot=%b led=%b buz=%b flt=%b want lvl=%0d mot=%b led=%b buz=%b flt=%b",
               nm, $time, a.lvl, a.mot, a.led, a.buz, a.flt,
               e.lvl, e.mot, e.led, e.buz, e.flt);
    end
  endtask

  task automatic model_reset();
    m_last = 0; m_run = 0; m_level = 0; m_ok = 0;
    m_st = M_OFF; m_since = 0; m_age = 0; m_buzz = 0;
  endtask

  task automatic model_step();
    int   nl;
    bit   rise;
    int   ns;
    bit   alarm;
    obs_t e;
    alarm = (m_level >= ALARM_TH) || (m_st == M_FAULT);
    if (alarm) begin
      m_buzz = (m_age % (2 * BUZZ_HALF)) < BUZZ_HALF;
      m_age++;
    end else begin
      m_buzz = 0;
      m_age  = 0;
    end
    nl   = m_level;
    rise = 0;
    if (m_run >= STABLE_N && m_last != m_level) begin
      nl   = m_last;
      rise = m_last > m_level;
    end
    ns = m_st;
    if (!enable) ns = M_OFF;
    else if (m_st == M_OFF) ns = M_IDLE;
    else if (m_st == M_IDLE) begin
      if (m_ok && m_level <= LOW_TH) ns = M_FILL;
    end else if (m_st == M_FILL) begin
      if (m_level >= HIGH_TH || m_level >= ALARM_TH) ns = M_IDLE;
      else if (m_since == DRY_TIMEOUT - 1) ns = M_FAULT;
    end
    if (m_st == M_FILL && ns == M_FILL) m_since = rise ? 0 : m_since + 1;
    else m_since = 0;
    if (nl != m_level) m_ok = 1;
    m_level = nl;
    m_st    = ns;
    if (sample_valid) begin
      if (int'(level_in) == m_last) m_run++;
      else begin
        m_last = int'(level_in);
        m_run  = 1;
      end
    end
    e.lvl = LVL_W'(m_level);
    e.mot = (m_st == M_FILL) && !(m_level >= ALARM_TH);
    e.led = m_ok && (m_level >= HIGH_TH);
    e.buz = m_buzz;
    e.flt = m_st == M_FAULT;
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      model_reset();
      q.delete();
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && q.size() > 0) begin
      mon_e = q.pop_front();
      check("cycle", outs(), mon_e);
    end
  end

  task automatic cyc(input logic v, input logic [LVL_W-1:0] d);
    @(negedge clk);
    #1;
    sample_valid = v;
    level_in     = d;
  endtask

  task automatic send(input int d, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, LVL_W'(d));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, level_in);
  endtask

  initial begin
    bit found;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset", outs(), '0);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    idle(6);
    send(50, 4);
    idle(4);
    send(80, 2); send(81, 1); send(80, 3);
    idle(2);
    send(80, 1);
    idle(3);
    send(100, 4); idle(3);
    send(191, 4); idle(3);
    send(192, 4); idle(3);
    send(100, 4); idle(3);
    send(64, 4);  idle(3);
    send(30, 4);
    idle(1100);
    enable = 1'b0;
    idle(5);
    enable = 1'b1;
    idle(3);
    idle(500);
    send(40, 4);
    idle(700);
    send(192, 4); idle(3);
    send(245, 4); idle(40);
    send(200, 4); idle(5);
    for (int i = 0; i < 400; i++) begin
      int r;
      int n;
      int v;
      r = $urandom_range(0, 99);
      if (r < 4) enable = ~enable;
      case ($urandom_range(0, 5))
        0: v = $urandom_range(0, 255);
        1: v = LOW_TH - 1 + $urandom_range(0, 2);
        2: v = HIGH_TH - 1 + $urandom_range(0, 2);
        3: v = ALARM_TH - 1 + $urandom_range(0, 2);
        4: v = int'(level_in);
        default: v = $urandom_range(0, 30);
      endcase
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++)
        cyc(($urandom_range(0, 9) < 8), LVL_W'(v));
    end
    enable = 1'b1;
    send(20, 4);
    found = 0;
    for (int k = 0; k < 1200 && !found; k++) begin
      @(negedge clk);
      if (fault && buzzer) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL fault_wait got fault=%b buzzer=%b want both 1", fault, buzzer);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", outs(), '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
